uart_rx_framed: RTL and testbench

//  Parametrised UART receiver: configurable data width, parity mode and stop-bit count.

---
 rtl/uart_rx_framed_if.sv | 33 +++
 rtl/uart_rx_framed.sv | 257 +++++++++++++++++++++++++
 tb/tb_uart_rx_framed.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_framed_if.sv
// Receive-side byte stream between uart_rx_framed and its consumer.
// The word, its per-frame error flags and the valid/ready pair travel together.
interface uart_rx_framed_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 rx_parity_err;
  logic                 rx_frame_err;
  logic                 rx_overrun;
  logic                 rx_break;

  modport master (
    output rx_data,
    output rx_valid,
    output rx_parity_err,
    output rx_frame_err,
    output rx_overrun,
    output rx_break,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  rx_parity_err,
    input  rx_frame_err,
    input  rx_overrun,
    input  rx_break,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_framed.sv
// UART receiver with majority-vote mid-bit sampling, false-start rejection and break detection.
// Completed frames and their error flags are held in a valid/ready output register.
module uart_rx_framed #(
  parameter int CLK_RATE    = 25000000,
  parameter int BAUD_RATE   = 115200,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_in,
  output logic             rx_busy,
  uart_rx_framed_if.master rx_if
);

  localparam int CLK_PER_BIT = CLK_RATE / BAUD_RATE;
  localparam int TW          = $clog2(CLK_PER_BIT);
  localparam int H           = CLK_PER_BIT / 2;
  localparam int BW          = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [TW-1:0] T_LAST = TW'(CLK_PER_BIT - 1);
  localparam logic [TW-1:0] T_S0   = TW'(H - 1);
  localparam logic [TW-1:0] T_S1   = TW'(H);
  localparam logic [TW-1:0] T_DEC  = TW'(H + 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
  localparam logic          S_LAST = 1'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_PARITY    = 3'd3;
  localparam logic [2:0] S_STOP      = 3'd4;
  localparam logic [2:0] S_WAIT_HIGH = 3'd5;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic xor_parity(input logic [DATA_BITS-1:0] word);
    return ^word;
  endfunction

  logic                 sync1_q, sync2_q, prev_q;
  logic [2:0]           state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 samp0_q, samp0_d;
  logic                 samp1_q, samp1_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 perr_acc_q, perr_acc_d;
  logic                 ferr_acc_q, ferr_acc_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 brk_q, brk_d;
  logic                 busy_q, busy_d;

  logic line_s, fall_s, wrap_s, decide_s, bit_s, frame_ferr_s, complete_s;

  assign line_s       = sync2_q;
  assign fall_s       = prev_q & ~sync2_q;
  assign wrap_s       = (timer_q == T_LAST);
  assign decide_s     = (timer_q == T_DEC);
  // Third vote is the live line in the decision cycle itself.
  assign bit_s        = majority3(samp0_q, samp1_q, line_s);
  assign frame_ferr_s = ferr_acc_q | ~bit_s;

  // Next-state logic: bit timer, sampling, frame FSM and output register.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    samp0_d    = samp0_q;
    samp1_d    = samp1_q;
    shreg_d    = shreg_q;
    perr_acc_d = perr_acc_q;
    ferr_acc_d = ferr_acc_q;
    data_d     = data_q;
    valid_d    = valid_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    ovr_d      = 1'b0;
    brk_d      = 1'b0;
    complete_s = 1'b0;

    if (state_q == S_IDLE || state_q == S_WAIT_HIGH) begin
      timer_d = '0;
    end else if (wrap_s) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + TW'(1);
    end

    if (timer_q == T_S0) begin
      samp0_d = line_s;
    end else if (timer_q == T_S1) begin
      samp1_d = line_s;
    end else begin
      samp0_d = samp0_q;
    end

    case (state_q)
      S_IDLE: begin
        if (fall_s) begin
          state_d    = S_START;
          bit_cnt_d  = '0;
          stop_cnt_d = 1'b0;
          perr_acc_d = 1'b0;
          ferr_acc_d = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (decide_s && bit_s) begin
          state_d = S_IDLE;
          timer_d = '0;
        end else if (wrap_s) begin
          state_d = S_DATA;
        end else begin
          state_d = S_START;
        end
      end
      S_DATA: begin
        if (decide_s) begin
          shreg_d = {bit_s, shreg_q[DATA_BITS-1:1]};
        end else if (wrap_s) begin
          if (bit_cnt_q == B_LAST) begin
            state_d = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_PARITY: begin
        if (decide_s) begin
          if (PARITY_MODE == 1) begin
            perr_acc_d = xor_parity(shreg_q) ^ bit_s;
          end else begin
            perr_acc_d = ~(xor_parity(shreg_q) ^ bit_s);
          end
        end else if (wrap_s) begin
          state_d = S_STOP;
        end else begin
          state_d = S_PARITY;
        end
      end
      S_STOP: begin
        if (decide_s) begin
          ferr_acc_d = frame_ferr_s;
          if (stop_cnt_q == S_LAST) begin
            // The frame completes at the final decision; the tail of the stop bit is not awaited.
            complete_s = 1'b1;
            timer_d    = '0;
            state_d    = frame_ferr_s ? S_WAIT_HIGH : S_IDLE;
          end else begin
            state_d = S_STOP;
          end
        end else if (wrap_s) begin
          stop_cnt_d = stop_cnt_q + 1'b1;
        end else begin
          state_d = S_STOP;
        end
      end
      S_WAIT_HIGH: begin
        if (line_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT_HIGH;
        end
      end
      default: begin
        state_d = S_IDLE;
        timer_d = '0;
      end
    endcase

    if (complete_s) begin
      brk_d = frame_ferr_s && (shreg_q == '0);
      if (!valid_q || rx_if.rx_ready) begin
        data_d  = shreg_q;
        perr_d  = perr_acc_q;
        ferr_d  = frame_ferr_s;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && rx_if.rx_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; synchroniser FFs reset high so reset never fakes a start edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      prev_q     <= 1'b1;
      state_q    <= S_IDLE;
      timer_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      samp0_q    <= 1'b0;
      samp1_q    <= 1'b0;
      shreg_q    <= '0;
      perr_acc_q <= 1'b0;
      ferr_acc_q <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
      brk_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      sync1_q    <= rx_in;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      state_q    <= state_d;
      timer_q    <= timer_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      samp0_q    <= samp0_d;
      samp1_q    <= samp1_d;
      shreg_q    <= shreg_d;
      perr_acc_q <= perr_acc_d;
      ferr_acc_q <= ferr_acc_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
      brk_q      <= brk_d;
      busy_q     <= busy_d;
    end
  end

  assign rx_if.rx_data       = data_q;
  assign rx_if.rx_valid      = valid_q;
  assign rx_if.rx_parity_err = perr_q;
  assign rx_if.rx_frame_err  = ferr_q;
  assign rx_if.rx_overrun    = ovr_q;
  assign rx_if.rx_break      = brk_q;
  assign rx_busy             = busy_q;

endmodule

// File: tb/tb_uart_rx_framed.sv
// Bench for uart_rx_framed: three configurations (8N1, 8E1, 7O2) driven with serial frames,
// accepted words compared against a frame-level reference model.
module tb_uart_rx_framed;
  localparam int CPB = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;
  logic rx_a = 1'b1, rx_b = 1'b1, rx_c = 1'b1;
  logic busy_a, busy_b, busy_c;

  uart_rx_framed_if #(.DATA_BITS(8)) if_a ();
  uart_rx_framed_if #(.DATA_BITS(8)) if_b ();
  uart_rx_framed_if #(.DATA_BITS(7)) if_c ();

  uart_rx_framed #(.CLK_RATE(1000000), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1))
    dut_a (.clk(clk), .reset(reset), .rx_in(rx_a), .rx_busy(busy_a), .rx_if(if_a));
  uart_rx_framed #(.CLK_RATE(1000000), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1))
    dut_b (.clk(clk), .reset(reset), .rx_in(rx_b), .rx_busy(busy_b), .rx_if(if_b));
  uart_rx_framed #(.CLK_RATE(1000000), .BAUD_RATE(100000), .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2))
    dut_c (.clk(clk), .reset(reset), .rx_in(rx_c), .rx_busy(busy_c), .rx_if(if_c));

  int checks = 0;
  int errors = 0;

  // Accepted words as {parity_err, frame_err, data[8:0]}.
  logic [10:0] acc_a[$], acc_b[$], acc_c[$];
  int ovr_a = 0, brk_a = 0, vcyc_a = 0, bcyc_a = 0, brk_c = 0;

  always @(negedge clk) begin
    if (if_a.rx_valid && if_a.rx_ready) acc_a.push_back({if_a.rx_parity_err, if_a.rx_frame_err, 1'b0, if_a.rx_data});
    if (if_b.rx_valid && if_b.rx_ready) acc_b.push_back({if_b.rx_parity_err, if_b.rx_frame_err, 1'b0, if_b.rx_data});
    if (if_c.rx_valid && if_c.rx_ready) acc_c.push_back({if_c.rx_parity_err, if_c.rx_frame_err, 2'b00, if_c.rx_data});
    if (if_a.rx_overrun) ovr_a++;
    if (if_a.rx_break) brk_a++;
    if (if_a.rx_valid) vcyc_a++;
    if (busy_a) bcyc_a++;
    if (if_c.rx_break) brk_c++;
  end

  // Serial bit sequence of one frame, line order (start first), returns its length in bits.
  function automatic int build(input int db, input logic [8:0] d, input int pm, input logic pbit,
                               input int ns, input logic [1:0] stops, output logic [31:0] bits);
    int n;
    bits = '1;
    n = 0;
    bits[n] = 1'b0; n++;
    for (int i = 0; i < db; i++) begin bits[n] = d[i]; n++; end
    if (pm != 0) begin bits[n] = pbit; n++; end
    for (int i = 0; i < ns; i++) begin bits[n] = stops[i]; n++; end
    return n;
  endfunction

  function automatic logic good_parity(input logic [8:0] d, input int pm);
    int ones;
    ones = $countones(d);
    return (pm == 1) ? logic'(ones % 2) : logic'((ones + 1) % 2);
  endfunction

  function automatic logic [10:0] exp_word(input logic [8:0] d, input int pm, input logic pbit,
                                           input int ns, input logic [1:0] stops);
    logic perr, ferr;
    perr = (pm == 0) ? 1'b0 : (pbit != good_parity(d, pm));
    ferr = (ns == 2) ? !(stops[0] && stops[1]) : !stops[0];
    return {perr, ferr, d};
  endfunction

  task automatic set_line(input int sel, input logic v);
    case (sel)
      0: rx_a = v;
      1: rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One clock per iteration; g_idx inverts that single clock, max_clk truncates the frame.
  task automatic drive(input int sel, input logic [31:0] bits, input int n, input int g_idx, input int max_clk);
    logic v;
    for (int i = 0; i < n * CPB; i++) begin
      if (max_clk >= 0 && i >= max_clk) break;
      v = bits[i / CPB];
      if (i == g_idx) v = ~v;
      set_line(sel, v);
      @(posedge clk);
      #1;
    end
    if (max_clk < 0) set_line(sel, 1'b1);
  endtask

  task automatic test_reset;
    logic [12:0] obs;
    idle(3);
    obs = {if_a.rx_valid, if_a.rx_data, if_a.rx_parity_err, if_a.rx_frame_err, if_a.rx_overrun, if_a.rx_break, busy_a};
    checks++;
    if (obs !== 13'd0) begin errors++; $display("FAIL reset_outputs got %h exp 0", obs); end
    reset = 1'b0;
    if_a.rx_ready = 1'b1; if_b.rx_ready = 1'b1; if_c.rx_ready = 1'b1;
    idle(5);
  endtask

  task automatic test_8n1;
    logic [31:0] bits; int n, n0, v0, o0, b0;
    n0 = acc_a.size(); v0 = vcyc_a; o0 = ovr_a; b0 = brk_a;
    n = build(8, 9'h0A5, 0, 1'b0, 1, 2'b11, bits);
    drive(0, bits, n, -1, -1);
    idle(30);
    checks++;
    if (acc_a.size() != n0 + 1) begin errors++; $display("FAIL 8n1_count got %0d exp 1", acc_a.size() - n0); end
    else begin
      checks++;
      if (acc_a[n0] !== exp_word(9'h0A5, 0, 1'b0, 1, 2'b11)) begin errors++; $display("FAIL 8n1_word got %h exp %h", acc_a[n0], exp_word(9'h0A5, 0, 1'b0, 1, 2'b11)); end
    end
    checks++;
    if (vcyc_a - v0 != 1) begin errors++; $display("FAIL 8n1_valid_cycles got %0d exp 1", vcyc_a - v0); end
    checks++;
    if (ovr_a != o0 || brk_a != b0) begin errors++; $display("FAIL 8n1_pulses got ovr %0d brk %0d exp 0 0", ovr_a - o0, brk_a - b0); end
  endtask

  task automatic test_parity;
    logic [31:0] bits; int n, n0;
    logic pb [2];
    pb[0] = 1'b1; pb[1] = 1'b0;
    n0 = acc_b.size();
    for (int k = 0; k < 2; k++) begin
      n = build(8, 9'h003, 1, pb[k], 1, 2'b11, bits);
      drive(1, bits, n, -1, -1);
      idle(30);
    end
    checks++;
    if (acc_b.size() != n0 + 2) begin errors++; $display("FAIL parity_count got %0d exp 2", acc_b.size() - n0); end
    else begin
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (acc_b[n0 + k] !== exp_word(9'h003, 1, pb[k], 1, 2'b11)) begin errors++; $display("FAIL parity_word%0d got %h exp %h", k, acc_b[n0 + k], exp_word(9'h003, 1, pb[k], 1, 2'b11)); end
      end
    end
  endtask

  task automatic test_break;
    logic [31:0] bits; int n, n0, b0;
    n0 = acc_a.size(); b0 = brk_a;
    rx_a = 1'b0;
    idle(30 * CPB);
    checks++;
    if (acc_a.size() != n0 + 1) begin errors++; $display("FAIL break_count got %0d exp 1", acc_a.size() - n0); end
    else begin
      checks++;
      if (acc_a[n0] !== exp_word(9'h000, 0, 1'b0, 1, 2'b00)) begin errors++; $display("FAIL break_word got %h exp %h", acc_a[n0], exp_word(9'h000, 0, 1'b0, 1, 2'b00)); end
    end
    checks++;
    if (brk_a - b0 != 1) begin errors++; $display("FAIL break_pulses got %0d exp 1", brk_a - b0); end
    checks++;
    if (busy_a !== 1'b1) begin errors++; $display("FAIL break_wait_busy got %b exp 1", busy_a); end
    rx_a = 1'b1;
    idle(2 * CPB);
    n = build(8, 9'h055, 0, 1'b0, 1, 2'b11, bits);
    drive(0, bits, n, -1, -1);
    idle(30);
    checks++;
    if (acc_a.size() != n0 + 2 || acc_a[acc_a.size() - 1] !== exp_word(9'h055, 0, 1'b0, 1, 2'b11))
      begin errors++; $display("FAIL break_recover got count %0d last %h exp 2 %h", acc_a.size() - n0, acc_a[acc_a.size() - 1], exp_word(9'h055, 0, 1'b0, 1, 2'b11)); end
    checks++;
    if (brk_a - b0 != 1) begin errors++; $display("FAIL break_once got %0d exp 1", brk_a - b0); end
  endtask

  task automatic test_glitch;
    logic [31:0] bits; int n, n0, c0;
    int gpos [2];
    gpos[0] = CPB * 3 + 6; gpos[1] = CPB * 6 + 5;
    n0 = acc_a.size(); c0 = bcyc_a;
    rx_a = 1'b0;
    idle(2);
    rx_a = 1'b1;
    idle(30);
    checks++;
    if (bcyc_a == c0 || busy_a !== 1'b0 || acc_a.size() != n0)
      begin errors++; $display("FAIL glitch_false_start got busy_cycles %0d busy %b frames %0d exp >0 0 0", bcyc_a - c0, busy_a, acc_a.size() - n0); end
    for (int k = 0; k < 2; k++) begin
      n = build(8, 9'h0B6, 0, 1'b0, 1, 2'b11, bits);
      drive(0, bits, n, gpos[k], -1);
      idle(30);
      checks++;
      if (acc_a.size() != n0 + k + 1 || acc_a[acc_a.size() - 1] !== exp_word(9'h0B6, 0, 1'b0, 1, 2'b11))
        begin errors++; $display("FAIL glitch_bit%0d got count %0d last %h exp %0d %h", k, acc_a.size() - n0, acc_a[acc_a.size() - 1], k + 1, exp_word(9'h0B6, 0, 1'b0, 1, 2'b11)); end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] b1, b2; int n1, n2, n0, o0;
    n0 = acc_a.size(); o0 = ovr_a;
    if_a.rx_ready = 1'b0;
    n1 = build(8, 9'h011, 0, 1'b0, 1, 2'b11, b1);
    n2 = build(8, 9'h022, 0, 1'b0, 1, 2'b11, b2);
    drive(0, b1, n1, -1, -1);
    drive(0, b2, n2, -1, -1);
    idle(30);
    checks++;
    if (ovr_a - o0 != 1) begin errors++; $display("FAIL b2b_overrun got %0d exp 1", ovr_a - o0); end
    checks++;
    if (if_a.rx_valid !== 1'b1 || if_a.rx_data !== 8'h11) begin errors++; $display("FAIL b2b_hold got valid %b data %h exp 1 11", if_a.rx_valid, if_a.rx_data); end
    if_a.rx_ready = 1'b1;
    @(posedge clk); #1;
    if_a.rx_ready = 1'b0;
    idle(1);
    checks++;
    if (if_a.rx_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got valid %b exp 0", if_a.rx_valid); end
    checks++;
    if (acc_a.size() != n0 + 1 || acc_a[acc_a.size() - 1] !== exp_word(9'h011, 0, 1'b0, 1, 2'b11))
      begin errors++; $display("FAIL b2b_word got count %0d last %h exp 1 %h", acc_a.size() - n0, acc_a[acc_a.size() - 1], exp_word(9'h011, 0, 1'b0, 1, 2'b11)); end
  endtask

  task automatic test_reset_mid_frame;
    logic [31:0] bits; int n, n0;
    logic [12:0] obs;
    n = build(8, 9'h077, 0, 1'b0, 1, 2'b11, bits);
    drive(0, bits, n, -1, -1);
    idle(30);
    checks++;
    if (if_a.rx_valid !== 1'b1 || if_a.rx_data !== 8'h77) begin errors++; $display("FAIL rst_pending got valid %b data %h exp 1 77", if_a.rx_valid, if_a.rx_data); end
    n = build(8, 9'h03C, 0, 1'b0, 1, 2'b11, bits);
    drive(0, bits, n, -1, CPB * 4 + 5);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    rx_a = 1'b1;
    obs = {if_a.rx_valid, if_a.rx_data, if_a.rx_parity_err, if_a.rx_frame_err, if_a.rx_overrun, if_a.rx_break, busy_a};
    checks++;
    if (obs !== 13'd0) begin errors++; $display("FAIL rst_mid_outputs got %h exp 0", obs); end
    n0 = acc_a.size();
    if_a.rx_ready = 1'b1;
    idle(3 * CPB);
    checks++;
    if (acc_a.size() != n0 || busy_a !== 1'b0) begin errors++; $display("FAIL rst_mid_discard got frames %0d busy %b exp 0 0", acc_a.size() - n0, busy_a); end
    drive(0, bits, n, -1, -1);
    idle(30);
    checks++;
    if (acc_a.size() != n0 + 1 || acc_a[acc_a.size() - 1] !== exp_word(9'h03C, 0, 1'b0, 1, 2'b11))
      begin errors++; $display("FAIL rst_mid_next got count %0d last %h exp 1 %h", acc_a.size() - n0, acc_a[acc_a.size() - 1], exp_word(9'h03C, 0, 1'b0, 1, 2'b11)); end
  endtask

  task automatic test_random_7o2;
    logic [31:0] bits; int n, n0, b0, exp_brk;
    logic [8:0] d; logic pbit; logic [1:0] stops; logic [10:0] w;
    logic [10:0] expq[$];
    n0 = acc_c.size(); b0 = brk_c; exp_brk = 0;
    for (int k = 0; k < 24; k++) begin
      d = (k % 6 == 5) ? 9'h000 : 9'($urandom_range(0, 127));
      pbit = good_parity(d, 2) ^ ($urandom_range(0, 3) == 0);
      stops = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
      w = exp_word(d, 2, pbit, 2, stops);
      expq.push_back(w);
      if (d == 9'h000 && w[9]) exp_brk++;
      n = build(7, d, 2, pbit, 2, stops, bits);
      drive(2, bits, n, -1, -1);
      idle(CPB * $urandom_range(1, 3));
    end
    idle(30);
    checks++;
    if (acc_c.size() != n0 + expq.size()) begin errors++; $display("FAIL rand_count got %0d exp %0d", acc_c.size() - n0, expq.size()); end
    else begin
      foreach (expq[k]) begin
        checks++;
        if (acc_c[n0 + k] !== expq[k]) begin errors++; $display("FAIL rand_word%0d got %h exp %h", k, acc_c[n0 + k], expq[k]); end
      end
    end
    checks++;
    if (brk_c - b0 != exp_brk) begin errors++; $display("FAIL rand_breaks got %0d exp %0d", brk_c - b0, exp_brk); end
  endtask

  initial begin
    if_a.rx_ready = 1'b0; if_b.rx_ready = 1'b0; if_c.rx_ready = 1'b0;
    test_reset();
    test_8n1();
    test_parity();
    test_break();
    test_glitch();
    test_back_to_back();
    test_reset_mid_frame();
    test_random_7o2();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
